// File: rtl/fan_tach_monitor.sv
// fan_tach_monitor: synchronises and debounces the fan tach line, counts its falling edges
// over a fixed gate window, reports RPM and flags a stalled fan.
// Latency: rpm/rpm_valid/stall/stall_irq update 1 clk after the gate's terminal cycle;
//          a tach level change reaches the edge counter after 2 sync flops + DEBOUNCE clks.
// Backpressure: none; rpm_valid and stall_irq are single-cycle pulses the consumer must sample.
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   tach       in   1   raw open-drain tach line, asynchronous to clk
//   rpm        out  16  RPM of the last completed window, saturating at 65535
//   rpm_valid  out  1   one-cycle pulse when rpm updates
//   stall      out  1   level, fan considered stalled
//   stall_irq  out  1   one-cycle pulse when stall rises
// Optional build macro FAN_TACH_MINMAX_EN adds:
//   minmax_clr in   1   synchronous reload of the min/max trackers
//   rpm_min    out  16  lowest rpm seen outside spin-up (reset 16'hFFFF)
//   rpm_max    out  16  highest rpm seen outside spin-up (reset 0)

module fan_tach_monitor #(
  parameter int GATE_CYCLES    = 1_600_000,
  parameter int RPM_SCALE      = 120,
  parameter int DEBOUNCE       = 16,
  parameter int STALL_WINDOWS  = 3,
  parameter int SPINUP_WINDOWS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tach,
  output logic [15:0] rpm,
  output logic        rpm_valid,
  output logic        stall,
  output logic        stall_irq
`ifdef FAN_TACH_MINMAX_EN
  ,
  input  logic        minmax_clr,
  output logic [15:0] rpm_min,
  output logic [15:0] rpm_max
`endif
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int WW = (SPINUP_WINDOWS > 1) ? $clog2(SPINUP_WINDOWS + 1) : 1;
  localparam int ZW = (STALL_WINDOWS > 1) ? $clog2(STALL_WINDOWS + 1) : 1;

  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [WW-1:0] SPIN_LAST = WW'(SPINUP_WINDOWS - 1);
  localparam logic [ZW-1:0] ZERO_LAST = ZW'(STALL_WINDOWS - 1);
  localparam logic [ZW-1:0] ZERO_MAX  = ZW'(STALL_WINDOWS);
  localparam logic [15:0]   SCALE     = 16'(RPM_SCALE);

  localparam logic [1:0] ST_SPINUP  = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_STALLED = 2'd2;

  // Input stage
  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          fall;

  // Gate / edge counting
  logic [GW-1:0] gate_q, gate_d;
  logic          terminal;
  logic [9:0]    edge_q, edge_d;
  logic [9:0]    win_e;
  logic [25:0]   prod;
  logic [15:0]   rpm_new;

  // Outputs and FSM
  logic [15:0]   rpm_q, rpm_d;
  logic          vld_q, vld_d;
  logic          stall_q, stall_d;
  logic          irq_q, irq_d;
  logic [1:0]    state_q, state_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [ZW-1:0] zero_cnt_q, zero_cnt_d;

  always_comb begin
    // Debounce: the count only advances while the synchronised level disagrees
    // with the accepted level; any agreeing cycle restarts it.
    deb_d     = deb_q;
    deb_cnt_d = '0;
    fall      = 1'b0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
        fall  = deb_q;            // accepted level goes 1->0
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    terminal = (gate_q == GATE_LAST);
    gate_d   = terminal ? '0 : gate_q + 1'b1;

    // win_e includes an edge landing on the terminal cycle itself.
    win_e  = (edge_q == 10'h3FF) ? edge_q : edge_q + {9'd0, fall};
    edge_d = terminal ? '0 : win_e;

    prod    = {16'd0, win_e} * {10'd0, SCALE};
    rpm_new = (|prod[25:16]) ? 16'hFFFF : prod[15:0];

    rpm_d      = rpm_q;
    vld_d      = 1'b0;
    stall_d    = stall_q;
    irq_d      = 1'b0;
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    zero_cnt_d = zero_cnt_q;

    if (terminal) begin
      rpm_d = rpm_new;
      vld_d = 1'b1;
      case (state_q)
        ST_SPINUP: begin
          win_cnt_d = win_cnt_q + 1'b1;
          if (win_cnt_q == SPIN_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (win_e == 10'd0) begin
            if (zero_cnt_q >= ZERO_LAST) begin
              zero_cnt_d = ZERO_MAX;
              state_d    = ST_STALLED;
              stall_d    = 1'b1;
              irq_d      = 1'b1;
            end else begin
              zero_cnt_d = zero_cnt_q + 1'b1;
            end
          end else begin
            zero_cnt_d = '0;
          end
        end
        ST_STALLED: begin
          // Clearing the stall is silent: only the rising edge interrupts.
          if (win_e != 10'd0) begin
            stall_d    = 1'b0;
            zero_cnt_d = '0;
            state_d    = ST_RUN;
          end
        end
        default: state_d = ST_SPINUP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b1;
      deb_cnt_q  <= '0;
      gate_q     <= '0;
      edge_q     <= '0;
      rpm_q      <= '0;
      vld_q      <= 1'b0;
      stall_q    <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= ST_SPINUP;
      win_cnt_q  <= '0;
      zero_cnt_q <= '0;
    end else begin
      sync1_q    <= tach;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      gate_q     <= gate_d;
      edge_q     <= edge_d;
      rpm_q      <= rpm_d;
      vld_q      <= vld_d;
      stall_q    <= stall_d;
      irq_q      <= irq_d;
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign rpm       = rpm_q;
  assign rpm_valid = vld_q;
  assign stall     = stall_q;
  assign stall_irq = irq_q;

`ifdef FAN_TACH_MINMAX_EN
  // track_q marks an rpm_valid cycle whose window closed outside spin-up;
  // the trackers fold rpm in on that cycle, so a coincident clear drops the sample.
  logic        track_q, track_d;
  logic [15:0] min_q, min_d;
  logic [15:0] max_q, max_d;

  always_comb begin
    track_d = terminal && (state_q != ST_SPINUP);
    min_d   = min_q;
    max_d   = max_q;
    if (minmax_clr) begin
      min_d = 16'hFFFF;
      max_d = 16'h0000;
    end else if (track_q) begin
      if (rpm_q < min_q) min_d = rpm_q;
      if (rpm_q > max_q) max_d = rpm_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      track_q <= 1'b0;
      min_q   <= 16'hFFFF;
      max_q   <= 16'h0000;
    end else begin
      track_q <= track_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign rpm_min = min_q;
  assign rpm_max = max_q;
`endif

endmodule

// File: tb/tb_fan_tach_monitor.sv
// tb_fan_tach_monitor: directed bench for fan_tach_monitor.
// Main instance: GATE_CYCLES=1000, DEBOUNCE=4, STALL_WINDOWS=3, SPINUP_WINDOWS=2.
// Second instance (GATE_CYCLES=3000, DEBOUNCE=1) is fed a 2-cycle tach to reach edge saturation.

module tb_fan_tach_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tach = 1'b1;
  logic        tach2 = 1'b1;
  logic [15:0] rpm, rpm2;
  logic        rpm_valid, rpm_valid2;
  logic        stall, stall2;
  logic        stall_irq, stall_irq2;
`ifdef FAN_TACH_MINMAX_EN
  logic        minmax_clr = 1'b0;
  logic [15:0] rpm_min, rpm_max, rpm_min2, rpm_max2;
`endif

  int checks = 0;
  int failures = 0;
  int mode = 0;     // 0 high, 1 low, 2 square 100-cycle, 3 2-cycle low glitch every 50
  int ph = 0;

  initial forever #5 clk = ~clk;

  // Toggle every cycle: one falling edge per 2 clks on the saturation instance.
  initial forever begin
    @(negedge clk);
    tach2 = ~tach2;
  end

  fan_tach_monitor #(
    .GATE_CYCLES(1000), .RPM_SCALE(120), .DEBOUNCE(4), .STALL_WINDOWS(3), .SPINUP_WINDOWS(2)
  ) dut (
    .clk(clk), .rst(rst), .tach(tach), .rpm(rpm), .rpm_valid(rpm_valid),
    .stall(stall), .stall_irq(stall_irq)
`ifdef FAN_TACH_MINMAX_EN
    , .minmax_clr(minmax_clr), .rpm_min(rpm_min), .rpm_max(rpm_max)
`endif
  );

  fan_tach_monitor #(
    .GATE_CYCLES(3000), .RPM_SCALE(120), .DEBOUNCE(1), .STALL_WINDOWS(3), .SPINUP_WINDOWS(2)
  ) u_sat (
    .clk(clk), .rst(rst), .tach(tach2), .rpm(rpm2), .rpm_valid(rpm_valid2),
    .stall(stall2), .stall_irq(stall_irq2)
`ifdef FAN_TACH_MINMAX_EN
    , .minmax_clr(minmax_clr), .rpm_min(rpm_min2), .rpm_max(rpm_max2)
`endif
  );

  task automatic step();
    @(negedge clk);
    ph++;
    case (mode)
      0: tach = 1'b1;
      1: tach = 1'b0;
      2: tach = ((ph % 100) < 50) ? 1'b1 : 1'b0;
      default: tach = ((ph % 50) < 2) ? 1'b0 : 1'b1;
    endcase
  endtask

  task automatic set_mode(input int m);
    mode = m;
    ph   = 0;
  endtask

  task automatic wait_valid(input int inst, input int maxc, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < maxc) begin
      step();
      n++;
      seen = (inst == 0) ? (rpm_valid === 1'b1) : (rpm_valid2 === 1'b1);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_valid inst=%0d: no rpm_valid within %0d cycles", inst, maxc);
    end
  endtask

  task automatic test_reset();
    set_mode(1);      // tach held low from reset for the spin-up scenario
    rst = 1'b1;
    #1;
    checks++; if (rpm !== 16'd0)     begin failures++; $display("FAIL reset_rpm: got %0d want 0", rpm); end
    checks++; if (rpm_valid !== 1'b0) begin failures++; $display("FAIL reset_rpm_valid: got %b want 0", rpm_valid); end
    checks++; if (stall !== 1'b0)     begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (stall_irq !== 1'b0) begin failures++; $display("FAIL reset_stall_irq: got %b want 0", stall_irq); end
`ifdef FAN_TACH_MINMAX_EN
    checks++; if (rpm_min !== 16'hFFFF) begin failures++; $display("FAIL reset_rpm_min: got %h want FFFF", rpm_min); end
    checks++; if (rpm_max !== 16'h0000) begin failures++; $display("FAIL reset_rpm_max: got %h want 0", rpm_max); end
`endif
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Tach low from reset: no stall during the 2 spin-up windows, stall at the 3rd RUN window.
  task automatic test_spinup_stall();
    int n;
    for (int w = 1; w <= 4; w++) begin
      wait_valid(0, 1100, n);
      if (w == 1) begin
        checks++; if (n !== 1000) begin failures++; $display("FAIL spinup_first_latency: got %0d cycles want 1000", n); end
      end
      checks++;
      if (stall !== 1'b0 || stall_irq !== 1'b0) begin
        failures++; $display("FAIL spinup_close%0d: stall=%b irq=%b want 0/0", w, stall, stall_irq);
      end
    end
    wait_valid(0, 1100, n);
    checks++; if (n !== 1000) begin failures++; $display("FAIL spinup_period: got %0d want 1000", n); end
    checks++;
    if (stall !== 1'b1 || stall_irq !== 1'b1) begin
      failures++; $display("FAIL spinup_stall_assert: stall=%b irq=%b want 1/1", stall, stall_irq);
    end
    step();
    checks++;
    if (stall !== 1'b1 || stall_irq !== 1'b0) begin
      failures++; $display("FAIL stall_irq_pulse: stall=%b irq=%b want 1/0", stall, stall_irq);
    end
  endtask

  // Restoring the tach clears stall at the next close without an irq.
  task automatic test_stall_clear();
    int n;
    set_mode(2);
    wait_valid(0, 1100, n);
    checks++;
    if (stall !== 1'b0 || stall_irq !== 1'b0) begin
      failures++; $display("FAIL stall_clear: stall=%b irq=%b want 0/0", stall, stall_irq);
    end
    checks++; if (rpm !== 16'd1200) begin failures++; $display("FAIL stall_clear_rpm: got %0d want 1200", rpm); end
  endtask

  task automatic test_rpm();
    int n;
    for (int w = 0; w < 2; w++) begin
      wait_valid(0, 1100, n);
      checks++; if (n !== 1000)     begin failures++; $display("FAIL rpm_period%0d: got %0d want 1000", w, n); end
      checks++; if (rpm !== 16'd1200) begin failures++; $display("FAIL rpm_value%0d: got %0d want 1200", w, rpm); end
      checks++; if (stall !== 1'b0)   begin failures++; $display("FAIL rpm_stall%0d: got %b want 0", w, stall); end
    end
    step();
    checks++;
    if (rpm_valid !== 1'b0 || rpm !== 16'd1200) begin
      failures++; $display("FAIL rpm_valid_pulse: valid=%b rpm=%0d want 0/1200", rpm_valid, rpm);
    end
  endtask

  task automatic test_glitch();
    int n;
    wait_valid(0, 1100, n);   // re-align to a window boundary
    set_mode(3);
    for (int w = 0; w < 2; w++) begin
      wait_valid(0, 1100, n);
      checks++; if (rpm !== 16'd0)  begin failures++; $display("FAIL glitch_rpm%0d: got %0d want 0", w, rpm); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL glitch_stall%0d: got %b want 0", w, stall); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    set_mode(2);
    for (int w = 0; w < 2; w++) begin
      wait_valid(0, 1100, n);
      checks++; if (rpm !== 16'd1200) begin failures++; $display("FAIL b2b_rpm%0d: got %0d want 1200", w, rpm); end
    end
  endtask

  // Hold tach high mid-window in RUN: that window still has edges, then 3 zero windows.
  task automatic test_stall_run();
    int n;
    repeat (520) step();
    set_mode(0);
    for (int w = 0; w < 3; w++) begin
      wait_valid(0, 1100, n);
      checks++;
      if (stall !== 1'b0 || stall_irq !== 1'b0) begin
        failures++; $display("FAIL run_prestall%0d: stall=%b irq=%b want 0/0", w, stall, stall_irq);
      end
    end
    wait_valid(0, 1100, n);
    checks++;
    if (stall !== 1'b1 || stall_irq !== 1'b1 || rpm !== 16'd0) begin
      failures++; $display("FAIL run_stall: stall=%b irq=%b rpm=%0d want 1/1/0", stall, stall_irq, rpm);
    end
  endtask

  // Edge accepted by the debouncer on the terminal cycle belongs to the closing window.
  task automatic test_terminal_edge();
    int n;
    repeat (993) step();
    set_mode(1);
    step();
    wait_valid(0, 20, n);
    checks++; if (n !== 6)        begin failures++; $display("FAIL term_align: got %0d want 6", n); end
    checks++; if (rpm !== 16'd120) begin failures++; $display("FAIL term_edge_rpm: got %0d want 120", rpm); end
    checks++;
    if (stall !== 1'b0 || stall_irq !== 1'b0) begin
      failures++; $display("FAIL term_stall_clear: stall=%b irq=%b want 0/0", stall, stall_irq);
    end
    wait_valid(0, 1100, n);
    checks++; if (rpm !== 16'd0) begin failures++; $display("FAIL term_next_rpm: got %0d want 0", rpm); end
  endtask

  task automatic test_saturation();
    int n;
    wait_valid(1, 3500, n);
    checks++; if (rpm2 !== 16'hFFFF) begin failures++; $display("FAIL sat_rpm0: got %0d want 65535", rpm2); end
    wait_valid(1, 3500, n);
    checks++; if (n !== 3000)        begin failures++; $display("FAIL sat_period: got %0d want 3000", n); end
    checks++; if (rpm2 !== 16'hFFFF) begin failures++; $display("FAIL sat_rpm1: got %0d want 65535", rpm2); end
  endtask

  task automatic test_midwindow_reset();
    int n;
    set_mode(2);
    wait_valid(0, 1100, n);
    wait_valid(0, 1100, n);
    checks++; if (rpm !== 16'd1200) begin failures++; $display("FAIL prereset_rpm: got %0d want 1200", rpm); end
    repeat (400) step();
`ifdef FAN_TACH_MINMAX_EN
    checks++; if (rpm_max !== 16'd1200) begin failures++; $display("FAIL minmax_track: got %0d want 1200", rpm_max); end
    minmax_clr = 1'b1;
    step();
    minmax_clr = 1'b0;
    checks++;
    if (rpm_min !== 16'hFFFF || rpm_max !== 16'h0000) begin
      failures++; $display("FAIL minmax_clr: min=%h max=%h want FFFF/0000", rpm_min, rpm_max);
    end
`endif
    rst = 1'b1;
    #1;
    checks++;
    if (rpm !== 16'd0 || rpm_valid !== 1'b0 || stall !== 1'b0 || stall_irq !== 1'b0 || rpm2 !== 16'd0) begin
      failures++; $display("FAIL midreset_outputs: rpm=%0d vld=%b stall=%b irq=%b rpm2=%0d want all 0",
                           rpm, rpm_valid, stall, stall_irq, rpm2);
    end
    set_mode(0);
    repeat (3) step();
    rst = 1'b0;
    // Back in SPINUP: 2 spin-up windows then 3 zero RUN windows before stall.
    for (int w = 1; w <= 4; w++) begin
      wait_valid(0, 1100, n);
      if (w == 1) begin
        checks++; if (n !== 1000) begin failures++; $display("FAIL midreset_latency: got %0d want 1000", n); end
      end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midreset_close%0d_stall: got %b want 0", w, stall); end
    end
    wait_valid(0, 1100, n);
    checks++;
    if (stall !== 1'b1 || stall_irq !== 1'b1) begin
      failures++; $display("FAIL midreset_stall: stall=%b irq=%b want 1/1", stall, stall_irq);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_spinup_stall();
    test_stall_clear();
    test_rpm();
    test_glitch();
    test_back_to_back();
    test_stall_run();
    test_terminal_edge();
    test_saturation();
    test_midwindow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
